// File: rtl/instr_mem_loader.sv
// Byte-stream instruction memory loader: packs MSB-first bytes into words and writes them from BASE_ADDR.
// Latency: one WRITE cycle after each 4th byte (4 bytes per 5 cycles). Backpressure: in_ready is low outside LOAD/CHECK.
// Optional trailing XOR checksum byte compiled in with LOADER_CHECKSUM_EN.
`ifndef INSTR_MEM_SIZE
`define INSTR_MEM_SIZE 1024
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module instr_mem_loader #(
    parameter int MEM_BYTES = `INSTR_MEM_SIZE,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [`WORD_LEN-1:0] mem_addr,
    output logic [`WORD_LEN-1:0] mem_wdata,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [`WORD_LEN-1:0] word_count
);

    localparam logic [`WORD_LEN-1:0] BASE_W = `WORD_LEN'(BASE_ADDR);
    localparam logic [`WORD_LEN-1:0] LAST_W = `WORD_LEN'(BASE_ADDR + MEM_BYTES - 4);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;
`endif

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic        last_word;
    logic        start_ok;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign mem_wdata = asm_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_hold  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    if (byte_idx == 2'd3) state_nxt = WRITE;
                    else if (in_last)     state_nxt = ERR;
                end
            end
            WRITE: begin
                mem_we   = 1'b1;
                cpu_hold = 1'b1;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end else if (mem_addr == LAST_W) begin
                    // The word just written filled the memory but the stream continues.
                    state_nxt = ERR;
                end else begin
                    state_nxt = LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) state_nxt = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= 2'd0;
            asm_word   <= 32'd0;
            last_word  <= 1'b0;
            mem_addr   <= BASE_W;
            word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                byte_idx   <= 2'd0;
                last_word  <= 1'b0;
                mem_addr   <= BASE_W;
                word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
            if (state == LOAD && in_valid) begin
                asm_word <= {asm_word[23:0], in_data};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) last_word <= in_last;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ in_data;
`endif
            end
            if (state == WRITE) begin
                mem_addr   <= mem_addr + `WORD_LEN'(4);
                word_count <= word_count + `WORD_LEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: default-size instance plus an 8-byte instance for overflow.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;

    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata, word_count;
    logic        in_ready2, mem_we2, cpu_hold2, done2, error2;
    logic [31:0] mem_addr2, mem_wdata2, word_count2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [31:0] wr_addr[$], wr_data[$], wr_addr2[$];
    bit          wr8_seen = 0;

    instr_mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
        .word_count(word_count)
    );

    instr_mem_loader #(.MEM_BYTES(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .cpu_hold(cpu_hold2), .done(done2), .error(error2),
        .word_count(word_count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (mem_we2) begin
            wr_addr2.push_back(mem_addr2);
            if (mem_addr2 == 32'd8) wr8_seen = 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input bit d2);
        if (d2) start2 = 1'b1;
        else    start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Present a byte at a negedge and return at the negedge after it is taken.
    task automatic send(input bit d2, input logic [7:0] b, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!(d2 ? in_ready2 : in_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_timeout", 32'(n >= 40), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done(output int at);
        int n = 0;
        at = -1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done) at = cyc;
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},     32'(mem_we),   32'd0);
        check({tag, "_in_ready"},   32'(in_ready), 32'd0);
        check({tag, "_cpu_hold"},   32'(cpu_hold), 32'd0);
        check({tag, "_done"},       32'(done),     32'd0);
        check({tag, "_error"},      32'(error),    32'd0);
        check({tag, "_word_count"}, word_count,    32'd0);
        check({tag, "_mem_addr"},   mem_addr,      32'd0);
        check({tag, "_mem_wdata"},  mem_wdata,     32'd0);
    endtask

    initial begin
        int c0, c1;
        logic [7:0] bv;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_error2", 32'(error2), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(cpu_hold), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        pulse_start(0);
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 1);
        send(0, 8'h04, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("csum_ok_done",  32'(done),  32'd1);
        check("csum_ok_error", 32'(error), 32'd0);
        check("csum_ok_data",  wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h01020304);

        pulse_start(0);
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 1);
        send(0, 8'h05, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_done",  32'(done),  32'd0);
        check("csum_bad_wcnt",  word_count, 32'd1);
`else
        // Single word
        pulse_start(0);
        check("a_ready",   32'(in_ready), 32'd1);
        check("a_hold",    32'(cpu_hold), 32'd1);
        send(0, 8'h84, 0); send(0, 8'hA0, 0); send(0, 8'h00, 0); send(0, 8'h08, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("a_writes",  32'(wr_addr.size()), 32'd1);
        check("a_addr",    wr_addr.size() > 0 ? wr_addr[0] : 32'hx, 32'd0);
        check("a_data",    wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h84A00008);
        check("a_done",    32'(done),     32'd1);
        check("a_error",   32'(error),    32'd0);
        check("a_wcnt",    word_count,    32'd1);
        check("a_hold_lo", 32'(cpu_hold), 32'd0);

        // 12 words streamed back to back
        wr_addr.delete(); wr_data.delete();
        pulse_start(0);
        check("b_done_clr", 32'(done), 32'd0);
        check("b_wcnt_clr", word_count, 32'd0);
        c0 = cyc;
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 4; k++) begin
                case (k)
                    0: bv = 8'(i);
                    1: bv = 8'hA5;
                    2: bv = 8'h5A;
                    default: bv = 8'hC3 ^ 8'(i);
                endcase
                send(0, bv, (i == 11 && k == 3));
                check("b_hold", 32'(cpu_hold), 32'd1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_done(c1);
        check("b_cycles", 32'(c1 - c0), 32'd60);
        @(negedge clk);
        check("b_writes", 32'(wr_addr.size()), 32'd12);
        for (int i = 0; i < 12 && i < wr_addr.size(); i++) begin
            check("b_addr", wr_addr[i], 32'(i * 4));
            check("b_data", wr_data[i], {8'(i), 8'hA5, 8'h5A, 8'hC3 ^ 8'(i)});
        end
        check("b_wcnt", word_count, 32'd12);

        // Partial second word
        wr_addr.delete(); wr_data.delete();
        pulse_start(0);
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0); send(0, 8'h44, 0);
        send(0, 8'h55, 0); send(0, 8'h66, 0); send(0, 8'h77, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(negedge clk);
        check("c_error",  32'(error), 32'd1);
        check("c_done",   32'(done),  32'd0);
        check("c_wcnt",   word_count, 32'd1);
        check("c_writes", 32'(wr_addr.size()), 32'd1);
        check("c_data",   wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h11223344);
        check("c_hold",   32'(cpu_hold), 32'd0);

        // Overflow of an 8-byte memory
        pulse_start(1);
        for (int k = 0; k < 8; k++) send(1, 8'(8'h10 + k), 0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h20 + k);
            in_last  = (k == 3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("d_error",  32'(error2), 32'd1);
        check("d_done",   32'(done2),  32'd0);
        check("d_writes", 32'(wr_addr2.size()), 32'd2);
        check("d_addr1",  wr_addr2.size() > 1 ? wr_addr2[1] : 32'hx, 32'd4);
        check("d_no8",    32'(wr8_seen), 32'd0);
        check("d_wcnt",   word_count2, 32'd2);
        check("d_ready",  32'(in_ready2), 32'd0);

        // Reset mid-word
        wr_addr.delete(); wr_data.delete();
        pulse_start(0);
        send(0, 8'hDE, 0); send(0, 8'hAD, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("e_rst");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hB0 + k);
            in_last  = (k == 5);
            @(negedge clk);
            check("e_ready_lo", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("e_no_write", 32'(wr_addr.size()), 32'd0);
        pulse_start(0);
        send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("e_writes", 32'(wr_addr.size()), 32'd1);
        check("e_addr",   wr_addr.size() > 0 ? wr_addr[0] : 32'hx, 32'd0);
        check("e_data",   wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h01020304);
        check("e_done",   32'(done), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default `INSTR_MEM_SIZE, the instruction memory capacity in bytes, a multiple of 4.
REQ-002 SHALL have parameter BASE_ADDR, default 0, the byte address of the first loaded word, word aligned.
REQ-003 SHALL have port clk, input, 1, the single system clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port in_valid, input, 1, meaning the byte-stream source has a byte on in_data.
REQ-007 SHALL have port in_data, input, 8, the stream byte; the first byte of each word is the most significant.
REQ-008 SHALL have port in_last, input, 1, marking the final byte of the stream, valid with in_valid.
REQ-009 SHALL have port in_ready, output, 1, meaning the loader accepts in_data this cycle.
REQ-010 SHALL have port mem_we, output, 1, the instruction memory word write strobe.
REQ-011 SHALL have port mem_addr, output, `WORD_LEN, the byte address of the word written.
REQ-012 SHALL have port mem_wdata, output, `WORD_LEN, the word written, with bits [31:24] stored at mem_addr and bits [7:0] stored at mem_addr+3.
REQ-013 SHALL have port cpu_hold, output, 1, which holds the pipeline in reset while a load is in progress.
REQ-014 SHALL have port done, output, 1, a level signal meaning the last load completed cleanly.
REQ-015 SHALL have port error, output, 1, a level signal meaning the last load aborted.
REQ-016 SHALL have port word_count, output, `WORD_LEN, the number of words written in the current or last load.

Function
REQ-017 SHALL implement the states IDLE, LOAD, WRITE, CHECK, DONE and ERR.
REQ-018 SHALL transfer a byte only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high in LOAD and CHECK only.
REQ-019 SHALL, on start in IDLE, DONE or ERR, go to LOAD on the next cycle, clear the byte index, word_count, done and error, and set mem_addr to BASE_ADDR.
REQ-020 SHALL ignore start while in LOAD, WRITE or CHECK.
REQ-021 SHALL shift each accepted byte into a 32-bit assembly register, MSB first, and increment a 2-bit byte index.
REQ-022 SHALL move from LOAD to WRITE when the 4th byte of a word (byte index 3) is accepted.
REQ-023 SHALL, in WRITE, assert mem_we for exactly one cycle with mem_addr and mem_wdata stable; mem_addr SHALL then advance by 4 and word_count SHALL increment, both visible on the following cycle.
REQ-024 SHALL, after WRITE, go to DONE (or to CHECK when checksum is enabled) if the 4th byte carried in_last, else return to LOAD.
REQ-025 SHALL go to ERR, with no write, if in_last arrives on a byte whose byte index is 0, 1 or 2 (partial word).
REQ-026 SHALL go to ERR after WRITE if the word just written was at BASE_ADDR+MEM_BYTES-4 and in_last was not set (overflow); no write SHALL occur outside the memory.
REQ-027 SHALL hold cpu_hold high in LOAD, WRITE and CHECK and low in all other states.
REQ-028 SHALL hold done high only in DONE and error high only in ERR.
REQ-029 SHALL give a throughput of 4 bytes per 5 cycles when in_valid is held high (4 accept cycles followed by 1 WRITE cycle).

Reset
REQ-030 SHALL, while rst is low, force the state to IDLE and drive mem_we=0, in_ready=0, cpu_hold=0, done=0, error=0, word_count=0, mem_addr=BASE_ADDR and mem_wdata=0, asynchronously.
REQ-031 SHALL abandon any load interrupted by reset with no further writes; the next load requires start.

Configuration
REQ-032 SHALL compile checksum checking in when LOADER_CHECKSUM_EN is defined: it keeps a running XOR of all data bytes and, in CHECK, accepts one extra byte; a match goes to DONE and a mismatch goes to ERR.
REQ-033 SHALL, without LOADER_CHECKSUM_EN, omit the CHECK state and the XOR logic, with WRITE of the in_last word going directly to DONE.

Verification
REQ-034 SHALL cover: reset, start, then stream 84 A0 00 08 with in_last on 08 -> one mem_we with mem_addr=0, mem_wdata=32'h84A00008; done=1; word_count=1.
REQ-035 SHALL cover: a 12-word stream with in_valid held high -> 12 writes at addresses 0,4,...,44; cpu_hold high throughout the load; 60 cycles from the first accept to DONE.
REQ-036 SHALL cover: in_last on the 3rd byte of word 2 -> ERR, error=1, word_count=1, no second write.
REQ-037 SHALL cover: MEM_BYTES=8 with a 3-word stream -> 2 writes, then ERR, with no write at address 8.
REQ-038 SHALL cover: rst pulsed low mid-word -> all outputs at reset values immediately, and no mem_we until a new start.
REQ-039 SHALL cover, with LOADER_CHECKSUM_EN defined: the stream 01 02 03 04 followed by checksum 04 -> DONE; checksum 05 -> ERR.
